mc8051_opnd_pipe: RTL and testbench
===================================

Name: mc8051_opnd_pipe

Overview:
- Parametrised, registered successor to the combinational operand/address mux of the mc8051 core.
- Takes one decoded command per handshake from the sequencer.
  - Selects the ALU operands, the memory write data and a memory address from a flattened source bus.
  - Snapshots all selected values at accept.
  - Issues 1–4 sequential address beats through a valid/ready output stage, for multi-byte push/pop/MOVX bursts.
- Sits between the control decoder and the memory/ALU interface.

Parameters:
- DW, 8: data width of each source and each operand.
- AW, 16: memory address width; must be ≥ 8.
- N_SRC, 8: number of DW-wide sources on i_src_bus.
- SW, $clog2(N_SRC): width of each source-select field (localparam).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_src_bus  in  N_SRC*DW  source k occupies bits [k*DW +: DW].
- i_acc  in  DW  accumulator, used by BASE_PLUS_ACC.
- i_psw_rs  in  2  register-bank select (PSW[4:3]).
- i_instr  in  8  current opcode.
- i_in0_sel  in  SW  ALU operand 0 source index.
- i_in1_kind  in  2  ALU operand 1 kind: 0=source, 1=+1, 2=all-ones, 3=zero.
- i_in1_sel  in  SW  ALU operand 1 source index.
- i_wd_sel  in  SW  write-data source index.
- i_addr_mode  in  3  address mode, see Behaviour.
- i_a_lo_sel  in  SW  low address source index.
- i_a_hi_sel  in  SW  high address source index.
- i_burst  in  2  beats minus 1.
- i_vld  in  1  command valid.
- o_rdy  out  1  command accept.
- o_vld  out  1  output beat valid.
- i_rdy  in  1  output beat accept.
- o_alu_in0  out  DW  registered operand 0.
- o_alu_in1  out  DW  registered operand 1.
- o_wdata  out  DW  registered write data.
- o_addr  out  AW  registered beat address.
- o_last  out  1  final beat of the command.
- o_in0_par  out  1  parity of o_alu_in0 (optional feature).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; all outputs 0; beat counter 0.
  - o_rdy=0 while reset is asserted, then 1 from the first clock edge after release.
  - Reset mid-burst abandons the burst with no further beats.
- States:
  - IDLE: o_vld=0, o_rdy=1.
  - ISSUE: o_vld=1.
- Accept: i_vld & o_rdy.
  - Next edge: o_vld=1 and all outputs hold the snapshot; beat 0 address = base address.
  - Latency from accept to first valid beat: 1 cycle.
- Stall: o_vld & !i_rdy holds every output stable, with no glitch on o_addr.
- Beat advance: o_vld & i_rdy & !o_last increments o_addr per the wrap rule and the counter by 1.
  - Data outputs stay constant across all beats of a command.
- o_last=1 when counter == burst (registered).
- o_rdy = IDLE | (o_vld & i_rdy & o_last).
  - Back-to-back commands give zero bubbles.
  - A simultaneous final beat and new accept loads the new snapshot; o_vld stays 1.
- Sources changing mid-burst have no effect, because of the snapshot.
- Out-of-range select (index ≥ N_SRC) yields 0.
- Address modes (base address; all results zero-extended to AW):
  - 0 RS: {rs,instr[2:0]}.
  - 1 RSI: {rs,2'b0,instr[0]}.
  - 2 IDX8: src[a_lo][7:0].
  - 3 IDX16: {src[a_hi],src[a_lo]}, truncated to AW.
  - 4 BASE_PLUS_ACC: {src[a_hi],src[a_lo]} + i_acc, mod 2^AW.
  - 5 BITM: b=src[a_lo][7:0]; if b[7]=0, 8'h20 + b[6:3]; else {b[7:3],3'b000}.
  - 6 SP: src[a_lo][7:0].
  - 7: reserved; address 0.
- Wrap rule:
  - Internal modes (0, 1, 2, 5, 6): increment mod 256; upper AW-8 bits stay 0.
  - External modes (3, 4): increment mod 2^AW.
- Operand 1 kinds 1/2/3 produce 1, {DW{1'b1}} and 0 respectively.

Optional Feature:
- Macro: MC8051_OPND_PARITY_EN.
- Defined: o_in0_par is registered alongside o_alu_in0, equal to ^src[in0_sel] at accept (PSW.P style); it holds during stalls and bursts, and resets to 0.
- Undefined: o_in0_par is tied to 0 and no parity logic is present.

Test Plan:
- Reset, then a command with in0_sel=2 (src2=8'h5A), in1_kind=1, mode 0, rs=2'b10, instr=8'hEB, burst=0; i_rdy=1 → 1 cycle later o_alu_in0=8'h5A, o_alu_in1=8'h01, o_addr=16'h0013, o_last=1; o_rdy=1 in the same cycle.
- Mode 6, src=8'hFE, burst=3, i_rdy=1 → addresses 0xFE, 0xFF, 0x00, 0x01; o_last on the 4th beat only.
- Mode 4, hi=8'hFF, lo=8'hF0, acc=8'h20, burst=1 → addresses 16'h0010, 16'h0011.
- Mode 5 with b=8'h0B → 16'h0021; with b=8'hE3 → 16'h00E0.
- Burst=2 with i_rdy held low 3 cycles at beat 1, and src changed during the stall → outputs frozen and unchanged; beats complete as 3 total; a new command accepted on the last beat produces no bubble.
- i_rst_n low mid-burst at beat 1 → o_vld=0 and all outputs 0 immediately. With MC8051_OPND_PARITY_EN and src=8'h07 → o_in0_par=1.

Source files
------------

// File: rtl/mc8051_opnd_pipe.sv
// mc8051_opnd_pipe: registered operand/write-data/address select with 1-4 beat address bursts (parity: MC8051_OPND_PARITY_EN).
// Latency: first beat 1 cycle after accept; a new command can be accepted on the final beat, so there are no bubbles.
// Backpressure: i_rdy low freezes every output; o_rdy is high only when idle or when the last beat is being taken.
module mc8051_opnd_pipe #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int N_SRC = 8,
  localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_SRC*DW-1:0] i_src_bus,
  input  logic [DW-1:0]       i_acc,
  input  logic [1:0]          i_psw_rs,
  input  logic [7:0]          i_instr,
  input  logic [SW-1:0]       i_in0_sel,
  input  logic [1:0]          i_in1_kind,
  input  logic [SW-1:0]       i_in1_sel,
  input  logic [SW-1:0]       i_wd_sel,
  input  logic [2:0]          i_addr_mode,
  input  logic [SW-1:0]       i_a_lo_sel,
  input  logic [SW-1:0]       i_a_hi_sel,
  input  logic [1:0]          i_burst,
  input  logic                i_vld,
  output logic                o_rdy,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic [DW-1:0]       o_alu_in0,
  output logic [DW-1:0]       o_alu_in1,
  output logic [DW-1:0]       o_wdata,
  output logic [AW-1:0]       o_addr,
  output logic                o_last,
  output logic                o_in0_par
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    logic [DW-1:0] wd;
    logic [AW-1:0] addr;
    logic          ext;
  } snap_t;

  state_t          state;
  logic            rdy_en;
  logic [1:0]      cnt;
  logic [1:0]      burst_q;
  logic            ext_q;
  logic            accept;
  logic            beat_adv;
  snap_t           nxt;
  logic [DW-1:0]   in0_src, in1_src, wd_src, a_lo, a_hi;
  logic [7:0]      lo8;
  logic [2*DW-1:0] pair;
  logic [7:0]      addr_lo_inc;
  logic [AW-1:0]   addr_inc;
  logic            unused_instr;

  // Selects beyond N_SRC fall through to zero.
  function automatic logic [DW-1:0] pick(input logic [N_SRC*DW-1:0] bus, input logic [SW-1:0] idx);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(idx) == k) r = bus[k*DW +: DW];
    end
    return r;
  endfunction

  assign unused_instr = ^i_instr[7:3];

  assign o_rdy    = rdy_en & ((state == IDLE) | (o_vld & i_rdy & o_last));
  assign accept   = i_vld & o_rdy;
  assign beat_adv = o_vld & i_rdy & ~o_last;

  always_comb begin
    in0_src = pick(i_src_bus, i_in0_sel);
    in1_src = pick(i_src_bus, i_in1_sel);
    wd_src  = pick(i_src_bus, i_wd_sel);
    a_lo    = pick(i_src_bus, i_a_lo_sel);
    a_hi    = pick(i_src_bus, i_a_hi_sel);
    lo8     = 8'(a_lo);
    pair    = {a_hi, a_lo};

    nxt     = '0;
    nxt.in0 = in0_src;
    nxt.wd  = wd_src;
    case (i_in1_kind)
      2'd0:    nxt.in1 = in1_src;
      2'd1:    nxt.in1 = DW'(1);
      2'd2:    nxt.in1 = '1;
      default: nxt.in1 = '0;
    endcase

    case (i_addr_mode)
      3'd0:       nxt.addr = AW'({i_psw_rs, i_instr[2:0]});
      3'd1:       nxt.addr = AW'({i_psw_rs, 2'b00, i_instr[0]});
      3'd2, 3'd6: nxt.addr = AW'(lo8);
      3'd3:       nxt.addr = AW'(pair);
      3'd4:       nxt.addr = AW'(pair) + AW'(i_acc);
      // Bit-addressable area: low half maps into 0x20-0x2F, high half onto SFR bases.
      3'd5:       nxt.addr = lo8[7] ? AW'({lo8[7:3], 3'b000})
                                    : AW'(8'h20 + {4'h0, lo8[6:3]});
      default:    nxt.addr = '0;
    endcase
    nxt.ext = (i_addr_mode == 3'd3) | (i_addr_mode == 3'd4);

    // Internal-RAM bursts wrap inside the 256-byte page; external ones span the full space.
    addr_lo_inc = o_addr[7:0] + 8'd1;
    addr_inc    = ext_q ? (o_addr + AW'(1)) : AW'(addr_lo_inc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      o_vld     <= 1'b0;
      o_alu_in0 <= '0;
      o_alu_in1 <= '0;
      o_wdata   <= '0;
      o_addr    <= '0;
      o_last    <= 1'b0;
      cnt       <= '0;
      burst_q   <= '0;
      ext_q     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        state     <= ISSUE;
        o_vld     <= 1'b1;
        o_alu_in0 <= nxt.in0;
        o_alu_in1 <= nxt.in1;
        o_wdata   <= nxt.wd;
        o_addr    <= nxt.addr;
        ext_q     <= nxt.ext;
        burst_q   <= i_burst;
        cnt       <= '0;
        o_last    <= (i_burst == 2'd0);
      end else if (beat_adv) begin
        o_addr <= addr_inc;
        cnt    <= cnt + 2'd1;
        o_last <= ((cnt + 2'd1) == burst_q);
      end else if (o_vld & i_rdy) begin
        state <= IDLE;
        o_vld <= 1'b0;
      end
    end
  end

`ifdef MC8051_OPND_PARITY_EN
  logic par_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^in0_src;
    end
  end

  assign o_in0_par = par_q;
`else
  assign o_in0_par = 1'b0;
`endif

endmodule

// File: tb/tb_mc8051_opnd_pipe.sv
// Scoreboard bench for mc8051_opnd_pipe: directed corner cases followed by random commands under random backpressure.
module tb_mc8051_opnd_pipe;
  localparam int DW = 8, AW = 16, N_SRC = 8, SW = 3;
`ifdef MC8051_OPND_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic [N_SRC*DW-1:0] i_src_bus = '0;
  logic [DW-1:0]       i_acc = '0;
  logic [1:0]          i_psw_rs = '0;
  logic [7:0]          i_instr = '0;
  logic [SW-1:0]       i_in0_sel = '0, i_in1_sel = '0, i_wd_sel = '0, i_a_lo_sel = '0, i_a_hi_sel = '0;
  logic [1:0]          i_in1_kind = '0, i_burst = '0;
  logic [2:0]          i_addr_mode = '0;
  logic                i_vld = 1'b0;
  logic                i_rdy;
  logic                rdy_rand = 1'b0, rdy_force = 1'b1, rdy_r = 1'b1;
  logic                o_rdy, o_vld, o_last, o_in0_par;
  logic [DW-1:0]       o_alu_in0, o_alu_in1, o_wdata;
  logic [AW-1:0]       o_addr;

  typedef struct {
    logic [DW-1:0] in0, in1, wd;
    logic [AW-1:0] addr;
    logic          last, par;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_vec = 0, n_err = 0;

  assign i_rdy = rdy_rand ? rdy_r : rdy_force;

  always #5 i_clk = ~i_clk;

  mc8051_opnd_pipe #(.DW(DW), .AW(AW), .N_SRC(N_SRC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src_bus(i_src_bus), .i_acc(i_acc),
    .i_psw_rs(i_psw_rs), .i_instr(i_instr), .i_in0_sel(i_in0_sel), .i_in1_kind(i_in1_kind),
    .i_in1_sel(i_in1_sel), .i_wd_sel(i_wd_sel), .i_addr_mode(i_addr_mode),
    .i_a_lo_sel(i_a_lo_sel), .i_a_hi_sel(i_a_hi_sel), .i_burst(i_burst),
    .i_vld(i_vld), .o_rdy(o_rdy), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_alu_in0(o_alu_in0), .o_alu_in1(o_alu_in1), .o_wdata(o_wdata), .o_addr(o_addr),
    .o_last(o_last), .o_in0_par(o_in0_par)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src(input int k);
    return int'(i_src_bus[k*DW +: DW]);
  endfunction

  // Reference address map computed directly from the mode table.
  function automatic int base_addr(input int mode, input int lo, input int hi, input int acc,
                                   input int rs, input int instr);
    case (mode)
      0:       return rs * 8 + instr % 8;
      1:       return rs * 8 + instr % 2;
      2, 6:    return lo;
      3:       return (hi * 256 + lo) % (1 << AW);
      4:       return (hi * 256 + lo + acc) % (1 << AW);
      5:       return (lo < 128) ? 32 + lo / 8 : (lo / 8) * 8;
      default: return 0;
    endcase
  endfunction

  task automatic push_expected();
    beat_t b;
    int    base, nb, mode;
    bit    ext;
    mode  = int'(i_addr_mode);
    b.in0 = DW'(src(int'(i_in0_sel)));
    case (int'(i_in1_kind))
      0:       b.in1 = DW'(src(int'(i_in1_sel)));
      1:       b.in1 = 8'h01;
      2:       b.in1 = 8'hFF;
      default: b.in1 = 8'h00;
    endcase
    b.wd  = DW'(src(int'(i_wd_sel)));
    b.par = PAR_EN ? ^b.in0 : 1'b0;
    base  = base_addr(mode, src(int'(i_a_lo_sel)), src(int'(i_a_hi_sel)), int'(i_acc),
                      int'(i_psw_rs), int'(i_instr));
    ext   = (mode == 3) || (mode == 4);
    nb    = int'(i_burst);
    for (int k = 0; k <= nb; k++) begin
      b.addr = AW'(ext ? (base + k) % (1 << AW) : (base + k) % 256);
      b.last = (k == nb);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Returns one time-step after the accepting edge, with beat 0 on the outputs.
  task automatic send();
    int t = 0;
    i_vld = 1'b1;
    @(negedge i_clk);
    while (!o_rdy && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: o_rdy=0 after %0d cycles, expected 1", t);
    end else begin
      push_expected();
    end
    tick();
    i_vld = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic set_src(input int k, input int v);
    i_src_bus[k*DW +: DW] = DW'(v);
  endtask

  task automatic set_cmd(input int in0, input int kind, input int in1, input int wd, input int mode,
                         input int lo, input int hi, input int burst, input int rs,
                         input int instr, input int acc);
    i_in0_sel = SW'(in0); i_in1_kind = 2'(kind); i_in1_sel = SW'(in1); i_wd_sel = SW'(wd);
    i_addr_mode = 3'(mode); i_a_lo_sel = SW'(lo); i_a_hi_sel = SW'(hi); i_burst = 2'(burst);
    i_psw_rs = 2'(rs); i_instr = 8'(instr); i_acc = DW'(acc);
  endtask

  task automatic rand_cmd();
    i_src_bus = {$urandom, $urandom};
    set_cmd($urandom_range(7), $urandom_range(3), $urandom_range(7), $urandom_range(7),
            $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(3),
            $urandom_range(3), $urandom_range(255), $urandom_range(255));
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    rdy_r = ($urandom_range(3) != 0);
  end

  always @(negedge i_clk) begin
    if (i_rst_n && o_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: addr %0h presented, expected no beat", o_addr);
      end else begin
        mon_b = exp_q[0];
        check("beat", 64'({o_alu_in0, o_alu_in1, o_wdata, o_addr, o_last, o_in0_par}),
              64'({mon_b.in0, mon_b.in1, mon_b.wd, mon_b.addr, mon_b.last, mon_b.par}));
        if (i_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2;
    check("reset_outputs", 64'({o_vld, o_rdy, o_last, o_in0_par, o_alu_in0, o_alu_in1, o_wdata, o_addr}), 64'(0));
    repeat (2) @(posedge i_clk);
    #1;
    check("rdy_in_reset", 64'(o_rdy), 64'(0));
    #1;
    i_rst_n = 1'b1;
    check("rdy_before_first_edge", 64'(o_rdy), 64'(0));
    tick();
    check("rdy_after_first_edge", 64'(o_rdy), 64'(1));

    // Single-beat command, register-bank address.
    set_src(2, 8'h5A);
    set_cmd(2, 1, 0, 0, 0, 0, 0, 0, 2, 8'hEB, 0);
    send();
    check("tp1_in0", 64'(o_alu_in0), 64'h5A);
    check("tp1_in1", 64'(o_alu_in1), 64'h01);
    check("tp1_addr", 64'(o_addr), 64'h0013);
    check("tp1_last_vld_rdy", 64'({o_last, o_vld, o_rdy}), 64'b111);
    drain();

    // Stack burst wrapping in the internal page.
    set_src(4, 8'hFE);
    set_cmd(1, 3, 0, 3, 6, 4, 0, 3, 0, 0, 0);
    send();
    check("sp_addr0", 64'(o_addr), 64'h00FE);
    tick(); tick();
    check("sp_addr2", 64'({o_addr, o_last}), 64'({16'h0000, 1'b0}));
    drain();

    // Base + accumulator wrapping in the full address space.
    set_src(1, 8'hFF);
    set_src(0, 8'hF0);
    set_cmd(0, 2, 0, 1, 4, 0, 1, 1, 0, 0, 8'h20);
    send();
    check("bpa_addr0", 64'(o_addr), 64'h0010);
    check("bpa_in1", 64'(o_alu_in1), 64'hFF);
    drain();

    set_src(3, 8'h0B);
    set_cmd(0, 0, 3, 0, 5, 3, 0, 0, 0, 0, 0);
    send();
    check("bitm_low", 64'(o_addr), 64'h0021);
    drain();
    set_src(3, 8'hE3);
    send();
    check("bitm_high", 64'(o_addr), 64'h00E0);
    drain();

    // Stall on beat 1 while sources change, then back-to-back accept on the last beat.
    set_src(5, 8'h33); set_src(6, 8'h44); set_src(7, 8'h10);
    set_cmd(5, 0, 6, 7, 6, 7, 0, 2, 0, 0, 0);
    send();
    tick();
    rdy_force = 1'b0;
    repeat (3) begin
      i_src_bus = {$urandom, $urandom};
      tick();
    end
    check("stall_hold", 64'({o_vld, o_addr, o_alu_in0, o_alu_in1, o_wdata}),
          64'({1'b1, 16'h0011, 8'h33, 8'h44, 8'h10}));
    rdy_force = 1'b1;
    tick();
    check("stall_last", 64'({o_addr, o_last}), 64'({16'h0012, 1'b1}));
    set_cmd(0, 3, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    send();
    check("no_bubble_vld", 64'(o_vld), 64'(1));
    drain();

    // Reset in the middle of a burst.
    set_src(0, 8'h07); set_src(1, 8'h80);
    set_cmd(0, 1, 0, 1, 2, 1, 0, 3, 0, 0, 0);
    send();
    check("parity_07", 64'(o_in0_par), 64'(PAR_EN ? 1 : 0));
    tick();
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midburst_reset", 64'({o_vld, o_rdy, o_last, o_in0_par, o_alu_in0, o_alu_in1, o_wdata, o_addr}), 64'(0));
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    check("after_reset_idle", 64'({o_vld, o_rdy}), 64'b01);

    // Random commands under random backpressure and random gaps.
    rdy_rand = 1'b1;
    repeat (250) begin
      rand_cmd();
      send();
      repeat ($urandom_range(2)) tick();
    end
    drain();
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
